sprite_scheduler: RTL
=====================

// Module: sprite_scheduler
// PURPOSE
//  Shares the single VGA plot port between N sprite engines (player, aliens, bullet) once per frame.
//  Each frame tick: erase every previously drawn sprite, then redraw every enabled sprite, one at a time.
//  Drives each engine's draw_signal/erase_signal and muxes the granted engine's x/y/colour onto the VGA adapter.
// PARAMETERS
//  N_SPR        4       number of sprite engines (1..8)
//  FRAME_DIV    833334  clk cycles per frame tick (60 Hz at 50 MHz)
//  ERASE_CYC    44      fixed cycles granted per erase (engine exports no erase-done)
//  DRAW_TMO     63      max cycles to wait for sprite_finish before forced advance
// PORTS
//  clk            in   1         system clock
//  reset          in   1         asynchronous, active-low reset
//  spr_en         in   N_SPR     per-sprite alive mask, sampled at frame tick
//  spr_x          in   9*N_SPR   packed engine x, sprite i at [9i+:9]
//  spr_y          in   8*N_SPR   packed engine y, sprite i at [8i+:8]
//  spr_colour     in   3*N_SPR   packed engine colour
//  spr_finish     in   N_SPR     engine draw-complete level
//  draw_signal    out  N_SPR     one-cycle draw request per engine
//  erase_signal   out  N_SPR     one-cycle erase request per engine
//  vga_x          out  9         muxed x of granted engine
//  vga_y          out  8         muxed y of granted engine
//  vga_colour     out  3         muxed colour of granted engine
//  vga_plot       out  1         write enable to VGA adapter
//  frame_tick     out  1         one-cycle pulse every FRAME_DIV cycles
//  busy           out  1         high whenever state != IDLE
//  overrun        out  1         sticky: tick arrived while busy
//  draw_tmo_err   out  1         sticky: a draw hit DRAW_TMO
// BEHAVIOUR
//  Reset (async, reset==0): all outputs 0; state IDLE; divider, index, drawn[] cleared.
//  Divider counts 0..FRAME_DIV-1; frame_tick pulses in cycle count==FRAME_DIV-1; runs in all states.
//  States: IDLE, E_REQ, E_WAIT, D_REQ, D_WAIT.
//  IDLE: on frame_tick latch en_q=spr_en, idx=0 -> E_REQ.
//  E_REQ: if drawn[idx]: erase_signal[idx]=1 one cycle, cnt=0 -> E_WAIT; else skip (idx+1, zero cycles in E_WAIT).
//  E_WAIT: grant idx; vga_plot=1; cnt++; at cnt==ERASE_CYC-1 clear drawn[idx], idx++; after idx==N_SPR-1 -> D_REQ with idx=0.
//  D_REQ: if en_q[idx]: draw_signal[idx]=1 one cycle, cnt=0 -> D_WAIT; else idx++ (skip).
//  D_WAIT: grant idx; vga_plot=1 while spr_finish[idx]==0; on spr_finish[idx]==1 set drawn[idx], idx++;
//    cnt==DRAW_TMO-1 without finish -> set draw_tmo_err, drawn[idx]=1, idx++. After last sprite -> IDLE.
//  Skip logic iterates one sprite per cycle; all disabled -> IDLE after N_SPR cycles per phase.
//  Grant mux: vga_x/y/colour = slice idx combinationally; forced 0 when no grant (IDLE/REQ states).
//  Erase never issued to a sprite not drawn since reset (engine would ignore it and stall next draw).
//  Sprite disabled mid-frame: no effect until next tick (en_q); still erased if drawn.
//  frame_tick while busy: tick dropped, overrun<=1 (sticky until reset).
//  Only one of draw_signal/erase_signal bits high in any cycle; never both.
//  Worst-case frame: N_SPR*(ERASE_CYC+DRAW_TMO+2)+2 cycles << FRAME_DIV.
// STRUCTURE
//  Package sprite_sched_pkg: state enum, XW=9, YW=8, CW=3, VGA_BLACK=3'b000.
//  Sub-module frame_divider (clk, reset, tick) holds FRAME_DIV counter.
//  Top: FSM + idx/cnt counters + drawn[] register + grant mux.
// TESTING
//  FRAME_DIV=200, N_SPR=4, spr_en=4'b1111, engines model finish after 40 cycles -> frame 1 no erase pulses, draw_signal 0,1,2,3 in order.
//  Frame 2 same setup -> erase_signal[0..3] each followed by exactly 44 grant cycles, then 4 draws.
//  spr_en=4'b0101 -> draws only sprites 0,2; next frame erases only 0,2; vga_plot low while skipping.
//  Engine 1 never asserts finish -> forced advance after 63 cycles, draw_tmo_err=1, sprites 2,3 still drawn.
//  FRAME_DIV=60 with 4 sprites -> overrun=1 on first tick during busy; schedule completes unaffected.
//  Assert reset during E_WAIT of sprite 2 -> all outputs 0 immediately; after release first frame issues no erase.

Source files
------------

// File: rtl/sprite_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sprite_sched_pkg                                             |
// | Description : Shared widths, colours and FSM encoding for sprite_scheduler |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package sprite_sched_pkg;

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  localparam logic [CW-1:0] VGA_BLACK = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_E_REQ  = 3'd1,
    S_E_WAIT = 3'd2,
    S_D_REQ  = 3'd3,
    S_D_WAIT = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_scheduler_frame_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : frame_divider                                                |
// | Description : Free-running 0..FRAME_DIV-1 counter, tick in the last count  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module frame_divider #(
  parameter int FRAME_DIV = 833334
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

  logic [DW-1:0] count_q;
  logic [DW-1:0] count_d;

  always_comb begin
    count_d = (count_q == DIV_LAST) ? '0 : count_q + DW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/sprite_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sprite_scheduler                                             |
// | Description : Per-frame erase-then-redraw arbiter of one VGA plot port     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module sprite_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int N_SPR     = 4,
  parameter int FRAME_DIV = 833334,
  parameter int ERASE_CYC = 44,
  parameter int DRAW_TMO  = 63
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_SPR-1:0]    spr_en,
  input  logic [XW*N_SPR-1:0] spr_x,
  input  logic [YW*N_SPR-1:0] spr_y,
  input  logic [CW*N_SPR-1:0] spr_colour,
  input  logic [N_SPR-1:0]    spr_finish,
  output logic [N_SPR-1:0]    draw_signal,
  output logic [N_SPR-1:0]    erase_signal,
  output logic [XW-1:0]       vga_x,
  output logic [YW-1:0]       vga_y,
  output logic [CW-1:0]       vga_colour,
  output logic                vga_plot,
  output logic                frame_tick,
  output logic                busy,
  output logic                overrun,
  output logic                draw_tmo_err
);

  localparam int IW      = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam int CNT_MAX = (ERASE_CYC > DRAW_TMO) ? ERASE_CYC : DRAW_TMO;
  localparam int NW      = $clog2(CNT_MAX + 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_SPR - 1);
  localparam logic [NW-1:0] ERASE_LAST = NW'(ERASE_CYC - 1);
  localparam logic [NW-1:0] TMO_LAST   = NW'(DRAW_TMO - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [N_SPR-1:0] en_q, en_d;
  logic [N_SPR-1:0] drawn_q, drawn_d;
  logic             overrun_q, overrun_d;
  logic             tmo_q, tmo_d;

  logic             tick;
  logic             idx_last;
  logic [IW-1:0]    idx_inc;
  logic             cur_drawn;
  logic             cur_en;
  logic             cur_finish;

  frame_divider #(.FRAME_DIV(FRAME_DIV)) u_frame_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign idx_last   = (idx_q == IDX_LAST);
  assign idx_inc    = idx_last ? '0 : idx_q + IW'(1);
  assign cur_drawn  = drawn_q[idx_q];
  assign cur_en     = en_q[idx_q];
  assign cur_finish = spr_finish[idx_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      en_q      <= '0;
      drawn_q   <= '0;
      overrun_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      drawn_q   <= drawn_d;
      overrun_q <= overrun_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    drawn_d   = drawn_q;
    tmo_d     = tmo_q;
    // Ticks landing mid-schedule are dropped, only flagged.
    overrun_d = overrun_q | (tick & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          en_d    = spr_en;
          idx_d   = '0;
          state_d = S_E_REQ;
        end
      end
      S_E_REQ: begin
        if (cur_drawn) begin
          cnt_d   = '0;
          state_d = S_E_WAIT;
        end else begin
          idx_d   = idx_inc;
          state_d = idx_last ? S_D_REQ : S_E_REQ;
        end
      end
      S_E_WAIT: begin
        cnt_d = cnt_q + NW'(1);
        if (cnt_q == ERASE_LAST) begin
          drawn_d[idx_q] = 1'b0;
          idx_d          = idx_inc;
          state_d        = idx_last ? S_D_REQ : S_E_REQ;
        end
      end
      S_D_REQ: begin
        if (cur_en) begin
          cnt_d   = '0;
          state_d = S_D_WAIT;
        end else begin
          idx_d   = idx_inc;
          state_d = idx_last ? S_IDLE : S_D_REQ;
        end
      end
      S_D_WAIT: begin
        cnt_d = cnt_q + NW'(1);
        // A timed-out sprite is still marked drawn so the next frame erases it.
        if (cur_finish || (cnt_q == TMO_LAST)) begin
          drawn_d[idx_q] = 1'b1;
          tmo_d          = tmo_q | ~cur_finish;
          idx_d          = idx_inc;
          state_d        = idx_last ? S_IDLE : S_D_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    draw_signal  = '0;
    erase_signal = '0;
    vga_x        = '0;
    vga_y        = '0;
    vga_colour   = VGA_BLACK;
    vga_plot     = 1'b0;
    case (state_q)
      S_E_REQ: erase_signal[idx_q] = cur_drawn;
      S_D_REQ: draw_signal[idx_q]  = cur_en;
      S_E_WAIT, S_D_WAIT: begin
        vga_x      = spr_x[int'(idx_q)*XW +: XW];
        vga_y      = spr_y[int'(idx_q)*YW +: YW];
        vga_colour = spr_colour[int'(idx_q)*CW +: CW];
        vga_plot   = (state_q == S_E_WAIT) ? 1'b1 : ~cur_finish;
      end
      default: ;
    endcase
  end

  assign frame_tick   = tick;
  assign busy         = (state_q != S_IDLE);
  assign overrun      = overrun_q;
  assign draw_tmo_err = tmo_q;

endmodule
`default_nettype wire
